// File: rtl/mtm_alu_pkg.sv
// Shared definitions for the MTM ALU serial front/back ends: FSM encoding,
// frame layout constants, error control codes and the result byte selector.
package mtm_alu_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_TYPE  = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4,
    S_GAP   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam int   FRAME_BITS = 11;
  localparam logic TYPE_DATA  = 1'b0;
  localparam logic TYPE_CTL   = 1'b1;

  localparam logic [7:0] ERR_DATA = 8'hC9;
  localparam logic [7:0] ERR_CRC  = 8'hA5;
  localparam logic [7:0] ERR_OP   = 8'h93;

  // Byte 0 is the most significant byte of the result word.
  function automatic logic [7:0] sel_byte(input logic [31:0] c, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = c[31:24];
      3'd1:    b = c[23:16];
      3'd2:    b = c[15:8];
      default: b = c[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mtm_alu_ser_frame.sv
// Single 11-bit frame shifter: on load emits the start bit, then type, d7..d0
// and stop, one bit per clock. The line rests at 1 whenever no frame is active.
module mtm_alu_ser_frame
  import mtm_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       frame_type,
  input  logic [7:0] data,
  output logic       sout,
  output logic       busy
);

  logic [9:0] sreg;
  logic [3:0] cnt;

  assign busy = (cnt != 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '1;
      cnt  <= 4'd0;
      sout <= 1'b1;
    end else if (load) begin
      // Start bit goes out on the load edge; the remaining bits queue in sreg.
      sout <= 1'b0;
      sreg <= {frame_type, data, 1'b1};
      cnt  <= 4'(FRAME_BITS - 1);
    end else if (busy) begin
      sout <= sreg[9];
      sreg <= {sreg[8:0], 1'b1};
      cnt  <= cnt - 4'd1;
    end else begin
      sout <= 1'b1;
    end
  end

endmodule

// File: rtl/mtm_alu_serializer.sv
// MTM ALU output serializer: frames result C and control byte onto sout.
// Optional macro MTM_ALU_SER_GAP_EN adds one idle bit after each non-final frame.
module mtm_alu_serializer
  import mtm_alu_pkg::*;
#(
  parameter int DATA_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] C,
  input  logic [7:0]  CTL_out,
  output logic        sout,
  output state_t      state_dbg,
  output logic        frame_busy
);

  // Handshake: a response is taken on any clock edge where in_valid and
  // in_ready are both 1; in_valid is ignored while in_ready is 0 (no queueing).

  localparam logic [2:0] NBYTES_NORMAL = 3'(DATA_BYTES);

  state_t      state_q, state_d;
  logic [2:0]  byte_cnt;
  logic [2:0]  bit_cnt;
  logic [2:0]  nbytes;
  logic [31:0] c_q;
  logic [7:0]  ctl_q;
  logic        accept;
  logic        load;
  logic        last_frame;
  logic        frame_type;
  logic [7:0]  frame_byte;

  assign accept     = in_valid & in_ready;
  assign last_frame = (byte_cnt == nbytes);
  assign frame_type = last_frame ? TYPE_CTL : TYPE_DATA;
  assign frame_byte = last_frame ? ctl_q : sel_byte(c_q, byte_cnt);
  assign state_dbg  = state_q;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_START;
      S_START: begin
        load    = 1'b1;
        state_d = S_TYPE;
      end
      S_TYPE:  state_d = S_DATA;
      S_DATA:  if (bit_cnt == 3'd7) state_d = S_STOP;
      S_STOP: begin
        if (last_frame) state_d = S_DONE;
`ifdef MTM_ALU_SER_GAP_EN
        else            state_d = S_GAP;
`else
        else            state_d = S_START;
`endif
      end
      S_GAP:   state_d = S_START;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      in_ready <= 1'b1;
      byte_cnt <= 3'd0;
      bit_cnt  <= 3'd0;
      nbytes   <= 3'd0;
      c_q      <= 32'd0;
      ctl_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        in_ready <= 1'b0;
        c_q      <= C;
        ctl_q    <= CTL_out;
        byte_cnt <= 3'd0;
        // Error responses carry only the control frame.
        nbytes   <= CTL_out[7] ? 3'd0 : NBYTES_NORMAL;
      end
      if (state_q == S_DATA) bit_cnt <= bit_cnt + 3'd1;
      if (state_q == S_STOP && !last_frame) byte_cnt <= byte_cnt + 3'd1;
      if (state_q == S_DONE) begin
        in_ready <= 1'b1;
        byte_cnt <= 3'd0;
      end
    end
  end

  mtm_alu_ser_frame u_frame (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .frame_type (frame_type),
    .data       (frame_byte),
    .sout       (sout),
    .busy       (frame_busy)
  );

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Self-checking bench for mtm_alu_serializer: expected frames are queued at
// accept time and a line monitor decodes sout and compares frame by frame.
module tb_mtm_alu_serializer;
  import mtm_alu_pkg::*;

  localparam int DATA_BYTES = 4;
`ifdef MTM_ALU_SER_GAP_EN
  localparam int GAP_BITS = DATA_BYTES;
`else
  localparam int GAP_BITS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] C = 32'd0;
  logic [7:0]  CTL_out = 8'd0;
  logic        sout;
  state_t      state_dbg;
  logic        frame_busy;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  mtm_alu_serializer #(.DATA_BYTES(DATA_BYTES)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .C          (C),
    .CTL_out    (CTL_out),
    .sout       (sout),
    .state_dbg  (state_dbg),
    .frame_busy (frame_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A normal response is DATA_BYTES data frames (MSB byte first) then the
  // control frame; an error response (ctl[7]=1) is the control frame alone.
  task automatic push_pkt(input logic [31:0] c, input logic [7:0] ctl);
    if (!ctl[7])
      for (int i = 0; i < DATA_BYTES; i++)
        exp_q.push_back({TYPE_DATA, 8'(c >> (8 * (DATA_BYTES - 1 - i)))});
    exp_q.push_back({TYPE_CTL, ctl});
  endtask

  function automatic int pkt_bits(input logic [7:0] ctl);
    return ctl[7] ? FRAME_BITS : (DATA_BYTES + 1) * FRAME_BITS + GAP_BITS;
  endfunction

  // ---------------- driver ----------------
  task automatic send(input logic [31:0] c, input logic [7:0] ctl,
                      input bit hold, input int poke_at, input int abort_at);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    C        = c;
    CTL_out  = ctl;
    @(posedge clk);
    push_pkt(c, ctl);
    #1;
    in_valid = hold;
    C        = $urandom;
    CTL_out  = 8'($urandom);
    @(negedge clk);
    chk("accept_ready_low", 32'(in_ready), 32'd0);
    chk("pre_start_idle", 32'(sout), 32'd1);
    @(negedge clk);
    chk("first_start_bit", 32'(sout), 32'd0);
    n = 1;
    while (in_ready !== 1'b1 && n < 300) begin
      if (abort_at != 0 && n == abort_at) begin
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_sout", 32'(sout), 32'd1);
        chk("abort_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        in_valid = 1'b0;
        return;
      end
      in_valid = hold || (n == poke_at);
      C        = (n == poke_at) ? 32'd0 : $urandom;
      @(negedge clk);
      n++;
    end
    chk("ready_latency", 32'(n), 32'(pkt_bits(ctl) + 1));
  endtask

  // ---------------- monitor / scoreboard ----------------
  int         pos = -1;
  logic [9:0] fr;
  bit         exp_gap = 1'b0;
  bit         exp_start = 1'b0;
  logic [8:0] e;

  always @(negedge clk) begin
    if (rst) begin
      pos       = -1;
      exp_gap   = 1'b0;
      exp_start = 1'b0;
      exp_q.delete();
    end else if (pos < 0) begin
      if (exp_gap) begin
        chk("gap_bit", 32'(sout), 32'd1);
        exp_gap   = 1'b0;
        exp_start = 1'b1;
      end else if (exp_start) begin
        chk("contiguous_start", 32'(sout), 32'd0);
        exp_start = 1'b0;
        fr        = '0;
        pos       = 1;
      end else if (sout === 1'b0) begin
        fr  = '0;
        pos = 1;
      end
    end else begin
      fr = {fr[8:0], sout};
      pos++;
      if (pos == FRAME_BITS) begin
        chk("stop_bit", 32'(fr[0]), 32'd1);
        chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("frame", 32'(fr[9:1]), 32'(e));
          if (e[8] == TYPE_DATA) begin
`ifdef MTM_ALU_SER_GAP_EN
            exp_gap = 1'b1;
`else
            exp_start = 1'b1;
`endif
          end
        end
        pos = -1;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rc;
    logic [7:0]  rctl;
    bit          rhold;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_sout", 32'(sout), 32'd1);
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_state", 32'(state_dbg), 32'(S_IDLE));
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("idle_sout", 32'(sout), 32'd1);
    end

    send(32'h12345678, 8'h2A, 1'b0, 0, 0);
    send(32'hFFFFFFFF, ERR_CRC, 1'b0, 0, 0);
    send(32'hDEADBEEF, 8'h15, 1'b0, 10, 0);
    send(32'hCAFEF00D, 8'h3C, 1'b0, 0, 20);
    send(32'h12345678, 8'h2A, 1'b0, 0, 0);
    send(32'h00000000, 8'h00, 1'b0, 0, 0);
    send(32'h87654321, ERR_DATA, 1'b1, 0, 0);
    send(32'h0F0F0F0F, ERR_OP, 1'b1, 0, 0);

    for (int i = 0; i < 24; i++) begin
      rc = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0:       rctl = ERR_DATA;
          1:       rctl = ERR_CRC;
          default: rctl = ERR_OP;
        endcase
      end else begin
        rctl = {1'b0, 7'($urandom)};
      end
      rhold = 1'($urandom_range(0, 1));
      send(rc, rctl, rhold, (i % 3 == 0) ? $urandom_range(2, 9) : 0, 0);
    end
    in_valid = 1'b0;

    repeat (20) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("final_idle", 32'(sout), 32'd1);
    chk("final_ready", 32'(in_ready), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
